// File: rtl/traffic_seq_ctrl.sv
// Command sequencer for one traffic generator: Init, one Fill per descriptor,
// then Dequeue ops gated by per-VC credit counters until the generator is done.
module traffic_seq_ctrl #(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 10,
    parameter int NUM_VC      = 4,
    parameter int VC_W        = 2,
    parameter int CRED_W      = 3,
    parameter int CREDIT_INIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_pkts,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [DATA_W-1:0] desc_data,
    input  logic [VC_W-1:0]   tg_vc,
    input  logic              tg_done,
    input  logic [NUM_VC-1:0] credit_ret,
    output logic [2:0]        op,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              credit_err
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_INIT = 3'd5;
    localparam logic [2:0] OP_FILL = 3'd6;
    localparam logic [2:0] OP_DEQ  = 3'd7;

    localparam int CW1 = CRED_W + 1;
    localparam logic [CRED_W:0]   CREDIT_LIM  = CW1'(CREDIT_INIT);
    localparam logic [CRED_W-1:0] CREDIT_RST  = CRED_W'(CREDIT_INIT);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        FILL,
        RUN,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   pkt_cnt, pkt_cnt_nxt;
    logic [CNT_W-1:0]   fill_cnt, fill_cnt_nxt;
    logic [CNT_W-1:0]   fill_cnt_inc;
    logic [2:0]         op_nxt;
    logic [DATA_W-1:0]  data_nxt;
    logic [NUM_VC-1:0]  deq_vc;
    logic [NUM_VC-1:0]  ovf_vec;
    logic               credit_ok;

    logic [CRED_W-1:0]  credit     [NUM_VC];
    logic [CRED_W-1:0]  credit_nxt [NUM_VC];

    assign fill_cnt_inc = fill_cnt + CNT_W'(1);
    assign credit_ok    = (credit[tg_vc] != '0);

    assign desc_ready = (state == FILL);
    assign busy       = (state == INIT) || (state == FILL) || (state == RUN);
    assign done       = (state == DONE);

    always_comb begin
        state_nxt    = state;
        pkt_cnt_nxt  = pkt_cnt;
        fill_cnt_nxt = fill_cnt;
        op_nxt       = OP_NOP;
        data_nxt     = data;
        deq_vc       = '0;

        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pkt_cnt_nxt  = num_pkts;
                        fill_cnt_nxt = '0;
                        state_nxt    = (num_pkts == '0) ? DONE : INIT;
                    end
                end
                INIT: begin
                    op_nxt    = OP_INIT;
                    data_nxt  = {pkt_cnt, {(DATA_W-CNT_W){1'b0}}};
                    state_nxt = FILL;
                end
                FILL: begin
                    if (desc_valid) begin
                        op_nxt       = OP_FILL;
                        data_nxt     = desc_data;
                        fill_cnt_nxt = fill_cnt_inc;
                        if (fill_cnt_inc == pkt_cnt) begin
                            state_nxt = RUN;
                        end
                    end
                end
                RUN: begin
                    // tg_done wins over a Dequeue in the same cycle
                    if (tg_done) begin
                        state_nxt = DONE;
                    end else if (credit_ok) begin
                        op_nxt         = OP_DEQ;
                        deq_vc[tg_vc]  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Per-VC credit update; an over-limit return is dropped and flagged
    for (genvar v = 0; v < NUM_VC; v++) begin : g_credit
        logic [CRED_W:0] sum;

        always_comb begin
            sum = {1'b0, credit[v]} - {{CRED_W{1'b0}}, deq_vc[v]}
                                    + {{CRED_W{1'b0}}, credit_ret[v]};
        end

        assign ovf_vec[v]    = (sum > CREDIT_LIM);
        assign credit_nxt[v] = ovf_vec[v]
                             ? (credit[v] - {{(CRED_W-1){1'b0}}, deq_vc[v]})
                             : sum[CRED_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pkt_cnt  <= '0;
            fill_cnt <= '0;
            op       <= OP_NOP;
            data     <= '0;
        end else begin
            state    <= state_nxt;
            pkt_cnt  <= pkt_cnt_nxt;
            fill_cnt <= fill_cnt_nxt;
            op       <= op_nxt;
            data     <= data_nxt;
        end
    end

    // Credits survive abort so in-flight returns are still counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                credit[v] <= CREDIT_RST;
            end
            credit_err <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                credit[v] <= credit_nxt[v];
            end
            credit_err <= credit_err | (|ovf_vec);
        end
    end

endmodule

// File: tb/tb_traffic_seq_ctrl.sv
// Directed bench for traffic_seq_ctrl: expected commands go into a scoreboard
// queue and a negedge monitor pops one per non-NOP op.
module tb_traffic_seq_ctrl;

    localparam logic [2:0] OP_INIT = 3'd5;
    localparam logic [2:0] OP_FILL = 3'd6;
    localparam logic [2:0] OP_DEQ  = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [9:0]  num_pkts;
    logic        desc_valid, desc_ready;
    logic [31:0] desc_data;
    logic [1:0]  tg_vc;
    logic        tg_done;
    logic [3:0]  credit_ret;
    logic [2:0]  op;
    logic [31:0] data;
    logic        busy, done, credit_err;

    traffic_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .num_pkts   (num_pkts),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_data  (desc_data),
        .tg_vc      (tg_vc),
        .tg_done    (tg_done),
        .credit_ret (credit_ret),
        .op         (op),
        .data       (data),
        .busy       (busy),
        .done       (done),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_data = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expectCmd(input logic [2:0] o, input logic [31:0] d);
        sb.push_back('{op: o, data: d});
        last_data = d;
    endtask

    task automatic expectDeq(input int n);
        for (int i = 0; i < n; i++) expectCmd(OP_DEQ, last_data);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drive one cycle of inputs; pulse-type inputs are cleared after the edge
    task automatic applyStimulus(input logic s, input logic a, input logic [9:0] n,
                                 input logic v, input logic [31:0] d, input logic [1:0] vc,
                                 input logic td, input logic [3:0] ret);
        start = s; abort = a; num_pkts = n; desc_valid = v; desc_data = d;
        tg_vc = vc; tg_done = td; credit_ret = ret;
        step();
        start = 1'b0; abort = 1'b0; desc_valid = 1'b0; credit_ret = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && op !== 3'd0) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_cmd: got op=%0d data=0x%0h, expected no command", op, data);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("cmd_op", {29'd0, op}, {29'd0, mon_e.op});
                checkOutput("cmd_data", data, mon_e.data);
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_pkts = '0; desc_valid = 1'b0;
        desc_data = '0; tg_vc = '0; tg_done = 1'b0; credit_ret = '0;
        #12;
        checkOutput("rst_op", {29'd0, op}, 32'd0);
        checkOutput("rst_data", data, 32'd0);
        checkOutput("rst_ready", {31'd0, desc_ready}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_err", {31'd0, credit_err}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        $display("[TB] run of 3 packets, dequeue on VC1");
        expectCmd(OP_INIT, 32'd3 << 22);
        applyStimulus(1, 0, 10'd3, 0, 0, 2'd1, 0, 4'b0000);
        applyStimulus(0, 0, 10'd0, 0, 0, 2'd1, 0, 4'b0000);
        checkOutput("fill_ready", {31'd0, desc_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            expectCmd(OP_FILL, 32'hA000_0000 + 32'(i));
            applyStimulus(0, 0, 10'd0, 1, 32'hA000_0000 + 32'(i), 2'd1, 0, 4'b0000);
        end
        checkOutput("ready_drop", {31'd0, desc_ready}, 32'd0);
        checkOutput("busy_run", {31'd0, busy}, 32'd1);
        expectDeq(4);
        tick(8);
        expectDeq(1);
        applyStimulus(0, 0, 10'd0, 0, 0, 2'd1, 0, 4'b0010);
        tick(4);

        $display("[TB] simultaneous dequeue and return on VC2, overflow on VC3");
        expectDeq(4);
        applyStimulus(0, 0, 10'd0, 0, 0, 2'd2, 0, 4'b0000);
        tick(6);
        applyStimulus(0, 0, 10'd0, 0, 0, 2'd2, 0, 4'b0100);
        expectDeq(2);
        applyStimulus(0, 0, 10'd0, 0, 0, 2'd2, 0, 4'b0100);
        tick(4);
        checkOutput("err_clear", {31'd0, credit_err}, 32'd0);
        applyStimulus(0, 0, 10'd0, 0, 0, 2'd2, 0, 4'b1000);
        checkOutput("err_set", {31'd0, credit_err}, 32'd1);
        expectDeq(4);
        applyStimulus(0, 0, 10'd0, 0, 0, 2'd3, 0, 4'b0000);
        tick(6);
        checkOutput("err_sticky", {31'd0, credit_err}, 32'd1);

        $display("[TB] tg_done with credits available");
        applyStimulus(0, 0, 10'd0, 0, 0, 2'd0, 1, 4'b0000);
        checkOutput("done_set", {31'd0, done}, 32'd1);
        checkOutput("done_busy", {31'd0, busy}, 32'd0);
        tick(2);

        $display("[TB] abort mid-fill");
        expectCmd(OP_INIT, 32'd3 << 22);
        applyStimulus(1, 0, 10'd3, 0, 0, 2'd0, 0, 4'b0000);
        applyStimulus(0, 0, 10'd0, 0, 0, 2'd0, 0, 4'b0000);
        checkOutput("restart_busy", {31'd0, busy}, 32'd1);
        checkOutput("restart_done", {31'd0, done}, 32'd0);
        expectCmd(OP_FILL, 32'h1234_5678);
        applyStimulus(0, 0, 10'd0, 1, 32'h1234_5678, 2'd0, 0, 4'b0000);
        applyStimulus(0, 1, 10'd0, 0, 0, 2'd0, 0, 4'b0000);
        checkOutput("abort_op", {29'd0, op}, 32'd0);
        checkOutput("abort_ready", {31'd0, desc_ready}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        tick(2);

        $display("[TB] zero-packet start");
        applyStimulus(1, 0, 10'd0, 0, 0, 2'd0, 0, 4'b0000);
        checkOutput("zero_done", {31'd0, done}, 32'd1);
        checkOutput("zero_busy", {31'd0, busy}, 32'd0);
        tick(2);

        $display("[TB] reset in the middle of a run");
        expectCmd(OP_INIT, 32'd1 << 22);
        applyStimulus(1, 0, 10'd1, 0, 0, 2'd0, 0, 4'b0000);
        applyStimulus(0, 0, 10'd0, 0, 0, 2'd0, 0, 4'b0000);
        expectCmd(OP_FILL, 32'hCAFE_0001);
        applyStimulus(0, 0, 10'd0, 1, 32'hCAFE_0001, 2'd0, 0, 4'b0000);
        expectDeq(2);
        tick(2);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_op", {29'd0, op}, 32'd0);
        checkOutput("mid_rst_data", data, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_done", {31'd0, done}, 32'd0);
        checkOutput("mid_rst_err", {31'd0, credit_err}, 32'd0);
        checkOutput("mid_rst_ready", {31'd0, desc_ready}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        $display("[TB] credits restored by reset on VC2");
        expectCmd(OP_INIT, 32'd1 << 22);
        applyStimulus(1, 0, 10'd1, 0, 0, 2'd2, 0, 4'b0000);
        applyStimulus(0, 0, 10'd0, 0, 0, 2'd2, 0, 4'b0000);
        expectCmd(OP_FILL, 32'h0BAD_F00D);
        applyStimulus(0, 0, 10'd0, 1, 32'h0BAD_F00D, 2'd2, 0, 4'b0000);
        expectDeq(4);
        tick(6);
        applyStimulus(0, 0, 10'd0, 0, 0, 2'd2, 1, 4'b0000);
        checkOutput("final_done", {31'd0, done}, 32'd1);
        tick(2);

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
